// File: rtl/spmv_pkg.sv
// Shared SpMV datapath types and constants.
// Holds the MLAB read latency and the FIFO occupancy-counter width helper.
package spmv_pkg;

    localparam int MLAB_RD_LAT = 1;

    typedef logic [1:0] stage_occ_t;

    // Occupancy counter must cover array depth plus head and skid.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/mlab_fifo_outstage.sv
// Purpose: head + skid output stage giving first-word-fall-through over a registered-read array.
// Latency: array word lands on the edge after it is read (one cycle behind inflight).
// Backpressure: holds up to two words; the parent only issues reads while a landing slot is free.
module mlab_fifo_outstage
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  rst_b,
    input  logic                  inflight,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  pop,
    output logic [1:0]            stage_occ,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  head_vld, head_vld_n;
    logic                  skid_vld, skid_vld_n;
    logic [DATA_WIDTH-1:0] head_dat, head_dat_n;
    logic [DATA_WIDTH-1:0] skid_dat, skid_dat_n;

    always_comb begin
        head_vld_n = head_vld;
        skid_vld_n = skid_vld;
        head_dat_n = head_dat;
        skid_dat_n = skid_dat;
        if (pop) begin
            // Skid advances into the head; a landing word always queues behind it.
            if (skid_vld) begin
                head_dat_n = skid_dat;
                skid_vld_n = inflight;
                if (inflight) begin
                    skid_dat_n = rdata;
                end
            end else begin
                head_vld_n = inflight;
                if (inflight) begin
                    head_dat_n = rdata;
                end
            end
        end else if (inflight) begin
            if (head_vld) begin
                skid_vld_n = 1'b1;
                skid_dat_n = rdata;
            end else begin
                head_vld_n = 1'b1;
                head_dat_n = rdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            head_dat <= '0;
            skid_dat <= '0;
        end else begin
            head_vld <= head_vld_n;
            skid_vld <= skid_vld_n;
            head_dat <= head_dat_n;
            skid_dat <= skid_dat_n;
        end
    end

    assign stage_occ = {1'b0, head_vld} + {1'b0, skid_vld};
    assign out_valid = head_vld;
    assign out_data  = head_dat;

endmodule

// File: rtl/mlab_stream_fifo.sv
`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 32
`endif
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 5
`endif
// Purpose: elastic ready/valid FIFO on an MLAB array with a head/skid fall-through stage.
// Latency: 2 cycles from push into an empty FIFO to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready drops while the array is full; head and skid keep draining.
module mlab_stream_fifo
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH = `LIM_BRICK_WORD_SIZE,
    parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK,
    parameter int CNT_WIDTH  = fifo_cnt_w(ADDR_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    stage_occ_t            stage_occ;
    logic [2:0]            stage_need;
    logic [DATA_WIDTH-1:0] rdata;

    (* ramstyle = "MLAB,no_rw_check" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ram_cnt never exceeds DEPTH, so its MSB alone flags a full array.
    assign in_ready = ~ram_cnt[ADDR_WIDTH];
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // ram_cnt excludes this cycle's push, so rd_ptr never equals a live wr_ptr.
    assign stage_need = 3'(stage_occ) + 3'(inflight) - 3'(pop);
    assign rd_en      = (ram_cnt != '0) && (stage_need < 3'd2);

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            ram_cnt  <= ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(rd_en);
            inflight <= rd_en;
            count    <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        if (rd_en) begin
            rdata <= mem[rd_ptr];
        end
    end

    assign empty = (count == '0);

    mlab_fifo_outstage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outstage (
        .CLK       (CLK),
        .rst_b     (rst_b),
        .inflight  (inflight),
        .rdata     (rdata),
        .pop       (pop),
        .stage_occ (stage_occ),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_mlab_stream_fifo.sv
// Bench for mlab_stream_fifo: cycle table for fill/latency, then queue-model checked random traffic.
module tb_mlab_stream_fifo;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int CW    = AW + 2;
    localparam int DEPTH = 4;
    localparam int CAP   = DEPTH + 2;

    logic          CLK = 1'b0;
    logic          rst_b;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          empty;

    mlab_stream_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK      (CLK),
        .rst_b    (rst_b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .empty    (empty)
    );

    always #5 CLK = ~CLK;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q[$];
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_dat;
    logic [DW-1:0] dut_pop_dat;
    int            cyc_no = 0;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          r;
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_od;
        int          e_cnt;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // One clock of traffic: compare the current outputs with the queue model, then drive.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r,
                       output bit acc, output bit popd);
        @(negedge CLK);
        cyc_no++;
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("cap", 32'(count <= CAP), 1);
        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", out_data, prev_dat);
        end
        if (out_valid) begin
            chk("valid_has_word", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("data_order", out_data, q[0]);
        end
        if (q.size() < DEPTH)    chk("in_ready_room", 32'(in_ready), 1);
        else if (q.size() >= CAP) chk("in_ready_full", 32'(in_ready), 0);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc       = v & in_ready;
        popd      = out_valid & r;
        prev_hold = out_valid & ~r;
        prev_dat  = out_data;
        if (popd) begin
            dut_pop_dat = out_data;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (acc) q.push_back(d);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_empty"}, 32'(empty), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc, popd;
        int n, guard, npops, first_pop, last_pop;

        // cycle-by-cycle fill to capacity, drain, then single-word latency
        tbl[0]  = '{1, 32'h1, 0, 1, 0, 32'h0, 0};
        tbl[1]  = '{1, 32'h2, 0, 1, 0, 32'h0, 1};
        tbl[2]  = '{1, 32'h3, 0, 1, 0, 32'h0, 2};
        tbl[3]  = '{1, 32'h4, 0, 1, 1, 32'h1, 3};
        tbl[4]  = '{1, 32'h5, 0, 1, 1, 32'h1, 4};
        tbl[5]  = '{1, 32'h6, 0, 1, 1, 32'h1, 5};
        tbl[6]  = '{1, 32'h7, 0, 0, 1, 32'h1, 6};
        tbl[7]  = '{0, 32'h0, 1, 0, 1, 32'h1, 6};
        tbl[8]  = '{0, 32'h0, 1, 1, 1, 32'h2, 5};
        tbl[9]  = '{0, 32'h0, 1, 1, 1, 32'h3, 4};
        tbl[10] = '{0, 32'h0, 1, 1, 1, 32'h4, 3};
        tbl[11] = '{0, 32'h0, 1, 1, 1, 32'h5, 2};
        tbl[12] = '{0, 32'h0, 1, 1, 1, 32'h6, 1};
        tbl[13] = '{1, 32'h11, 1, 1, 0, 32'h6, 0};
        tbl[14] = '{0, 32'h0, 1, 1, 0, 32'h6, 1};
        tbl[15] = '{0, 32'h0, 1, 1, 0, 32'h6, 1};
        tbl[16] = '{0, 32'h0, 1, 1, 1, 32'h11, 1};
        tbl[17] = '{0, 32'h0, 0, 1, 0, 32'h11, 0};

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_b     = 1'b0;
        repeat (2) @(negedge CLK);
        rst_b = 1'b1;
        chk_reset_state("reset");

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            cyc_no++;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("tbl%0d_count", i), 32'(count), tbl[i].e_cnt);
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            out_ready = tbl[i].r;
        end

        // reset asserted while the read of the second word is in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            in_valid  = 1'b1;
            in_data   = 32'hB0 + k;
            out_ready = 1'b0;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        rst_b    = 1'b0;
        @(negedge CLK);
        rst_b = 1'b1;
        chk_reset_state("midreset");
        q.delete();
        prev_hold = 1'b0;
        cyc(1'b1, 32'hA5, 1'b1, acc, popd);
        chk("post_reset_accept", 32'(acc), 1);
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            cyc(1'b0, '0, 1'b1, acc, popd);
            guard++;
        end
        chk("post_reset_drained", q.size(), 0);
        chk("post_reset_first", dut_pop_dat, 32'hA5);

        // streaming: push every cycle with a ready consumer
        npops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, $urandom, 1'b1, acc, popd);
            chk("stream_accept", 32'(acc), 1);
            chk("stream_cnt_le3", 32'(count <= 3), 1);
            if (popd) begin
                npops++;
                if (first_pop < 0) first_pop = cyc_no;
                last_pop = cyc_no;
            end
        end
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            cyc(1'b0, '0, 1'b1, acc, popd);
            guard++;
            if (popd) begin
                npops++;
                if (first_pop < 0) first_pop = cyc_no;
                last_pop = cyc_no;
            end
        end
        chk("stream_pops", npops, 20);
        chk("stream_no_bubble", last_pop - first_pop, 19);

        // random producer/consumer backpressure
        n = 0; guard = 0;
        while (n < 200 && guard < 3000) begin
            cyc(($urandom_range(0, 99) < 70), $urandom, 1'($urandom_range(0, 1)), acc, popd);
            if (acc) n++;
            guard++;
        end
        chk("bp_words_sent", n, 200);
        guard = 0;
        while (q.size() != 0 && guard < 40) begin
            cyc(1'b0, '0, 1'($urandom_range(0, 1)), acc, popd);
            guard++;
        end
        chk("bp_drained", q.size(), 0);

        // repeated 5-word fill/drain walks the pointers round the array
        for (int it = 0; it < 10; it++) begin
            n = 0; guard = 0;
            while (n < 5 && guard < 20) begin
                cyc(1'b1, $urandom, 1'b0, acc, popd);
                if (acc) n++;
                guard++;
            end
            chk("wrap_fill", n, 5);
            guard = 0;
            while (q.size() != 0 && guard < 20) begin
                cyc(1'b0, '0, 1'b1, acc, popd);
                guard++;
            end
            chk("wrap_drained", q.size(), 0);
        end
        cyc(1'b0, '0, 1'b0, acc, popd);
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_out_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
